// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C bus conditioner front end.
`timescale 1ns/1ps
package i2c_pkg;

  // Default glitch-filter depth, in clk samples.
  localparam int FILTER_LEN_DEF = 3;

  // Default SCL-stuck-low limit: 1 ms at 50 MHz.
  localparam int TIMEOUT_CYCLES_DEF = 50000;

  // Level of an idle (released, pulled-up) I2C line.
  localparam logic IDLE_LEVEL = 1'b1;

  // Width of the per-line glitch-filter counter.
  localparam int FILT_CNT_W = 4;

  // One sample of both bus lines.
  typedef struct packed {
    logic scl;
    logic sda;
  } line_pair_t;

endpackage

// File: rtl/i2c_bus_conditioner_if.sv
// Bus-side bundle between the pads, the conditioner and the slave protocol FSM.
// master: the conditioner (takes raw pads, drives levels and strobes).
// slave:  the consumer (drives raw pads in a bench, samples strobes).
`timescale 1ns/1ps
interface i2c_bus_conditioner_if;

  logic scl_in;
  logic sda_in;
  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_busy;
  logic timeout;

  modport master (
    input  scl_in, sda_in,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
  );

  modport slave (
    output scl_in, sda_in,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
  );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer plus majority-free run-length glitch filter for one
// I2C line. The filtered level only follows the synchronized level after it
// has held a new value for FILTER_LEN consecutive clk samples.
`timescale 1ns/1ps
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_f
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

  logic [1:0]            sync_q;
  logic [FILT_CNT_W-1:0] cnt_q;

  // Synchronize the pad, then count consecutive samples that disagree with
  // the filtered level; flip the filtered level on the FILTER_LEN-th one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {2{IDLE_LEVEL}};
      cnt_q  <= '0;
      line_f <= IDLE_LEVEL;
    end else begin
      // NOTE: non-blocking so sync_q[1] and line_f below read the values from
      // before this edge; blocking here would collapse the synchronizer.
      sync_q <= {sync_q[0], line_in};
      if (sync_q[1] == line_f) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        line_f <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C bus conditioner: synchronizes and de-glitches SCL/SDA, then produces
// registered SCL edge strobes, START/STOP pulses, a bus-busy flag and an
// optional SCL-stuck-low timeout.
// Build option: define I2C_BUS_TIMEOUT_EN to include the timeout counter;
// without it timeout stays 0 and bus_busy clears only on STOP.
`timescale 1ns/1ps
module i2c_bus_conditioner
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_bus_conditioner_if.master bus
);

  logic       scl_f;
  logic       sda_f;
  line_pair_t prev_q;
  logic       start_cond;
  logic       stop_cond;
  logic       tmo_hit;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_det_q;
  logic       stop_det_q;
  logic       bus_busy_q;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (bus.scl_in),
    .line_f  (scl_f)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (bus.sda_in),
    .line_f  (sda_f)
  );

  // START/STOP need SCL high on both samples, so an SDA change in the same
  // cycle as an SCL change never qualifies; only the SCL strobe fires then.
  assign start_cond = prev_q.scl & scl_f &  prev_q.sda & ~sda_f;
  assign stop_cond  = prev_q.scl & scl_f & ~prev_q.sda &  sda_f;

  // Register previous filtered levels and the one-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q      <= '{scl: IDLE_LEVEL, sda: IDLE_LEVEL};
      scl_rise_q  <= 1'b0;
      scl_fall_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      prev_q      <= '{scl: scl_f, sda: sda_f};
      scl_rise_q  <= ~prev_q.scl &  scl_f;
      scl_fall_q  <=  prev_q.scl & ~scl_f;
      start_det_q <= start_cond;
      stop_det_q  <= stop_cond;
    end
  end

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int                  TMO_CNT_W = 20;
  localparam logic [TMO_CNT_W-1:0] TMO_LAST  = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt_q;
  logic                 timeout_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive busy cycle with SCL low.
  assign tmo_hit = bus_busy_q & ~scl_f & (tmo_cnt_q == TMO_LAST);

  // Count busy low-SCL cycles; clear on any break or after firing. Since
  // firing drops bus_busy, it cannot fire again before the next START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (bus_busy_q & ~scl_f & ~tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;

  // Constant 0 in this build; TIMEOUT_CYCLES only feeds an always-false
  // compare so the parameter list stays identical in both builds.
  assign bus.timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Bus-busy flag: START (including repeated START) wins over STOP/timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_busy_q <= 1'b0;
    end else if (start_cond) begin
      bus_busy_q <= 1'b1;
    end else if (stop_cond | tmo_hit) begin
      bus_busy_q <= 1'b0;
    end
  end

  assign bus.scl_f     = scl_f;
  assign bus.sda_f     = sda_f;
  assign bus.scl_rise  = scl_rise_q;
  assign bus.scl_fall  = scl_fall_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;
  assign bus.bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Self-checking bench for i2c_bus_conditioner: directed scenarios plus
// randomized transactions with glitches, compared every cycle against a
// reference model built from pad history (line delays, run-length filter
// rule, bus-condition rules). Honors I2C_BUS_TIMEOUT_EN like the design.
`timescale 1ns/1ps
module tb_i2c_bus_conditioner;

  localparam int FL  = 3;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  i2c_bus_conditioner_if bus ();

  i2c_bus_conditioner #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit cur_scl = 1'b1, cur_sda = 1'b1;
  bit pads_scl[$], pads_sda[$];
  bit seen_scl[$], seen_sda[$];
  bit m_scl_f, m_sda_f, m_scl_p, m_sda_p;
  bit m_rise, m_fall, m_start, m_stop, m_busy, m_tmo;
  int low_run;

  task automatic model_reset();
    pads_scl.delete(); pads_sda.delete();
    seen_scl.delete(); seen_sda.delete();
    m_scl_f = 1; m_sda_f = 1; m_scl_p = 1; m_sda_p = 1;
    m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_busy = 0; m_tmo = 0;
    low_run = 0;
  endtask

  // The filter sees the pad value from two edges earlier (idle before that).
  function automatic bit sync_view(input bit pads[$]);
    return (pads.size() >= 3) ? pads[pads.size()-3] : 1'b1;
  endfunction

  // New level is adopted once the last FL samples all differ from it.
  function automatic bit filt_next(input bit seen[$], input bit cur);
    if (seen.size() < FL) return cur;
    for (int i = 1; i <= FL; i++)
      if (seen[seen.size()-i] == cur) return cur;
    return !cur;
  endfunction

  task automatic model_step();
    bit nf_scl, nf_sda, st, sp, tmo;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pads_scl.push_back(cur_scl); pads_sda.push_back(cur_sda);
    seen_scl.push_back(sync_view(pads_scl)); seen_sda.push_back(sync_view(pads_sda));
    if (pads_scl.size() > 20) begin void'(pads_scl.pop_front()); void'(pads_sda.pop_front()); end
    if (seen_scl.size() > 20) begin void'(seen_scl.pop_front()); void'(seen_sda.pop_front()); end
    nf_scl = filt_next(seen_scl, m_scl_f);
    nf_sda = filt_next(seen_sda, m_sda_f);
    // Conditions seen between the filtered levels one and two cycles back.
    st  = m_scl_p && m_scl_f && m_sda_p && !m_sda_f;
    sp  = m_scl_p && m_scl_f && !m_sda_p && m_sda_f;
    tmo = 0;
`ifdef I2C_BUS_TIMEOUT_EN
    if (m_busy && !m_scl_f) low_run++;
    else low_run = 0;
    if (low_run == TMO) begin
      tmo = 1;
      low_run = 0;
    end
`endif
    m_rise  = !m_scl_p && m_scl_f;
    m_fall  = m_scl_p && !m_scl_f;
    m_start = st;
    m_stop  = sp;
    m_tmo   = tmo;
    if (st) m_busy = 1;
    else if (sp || tmo) m_busy = 0;
    m_scl_p = m_scl_f; m_sda_p = m_sda_f;
    m_scl_f = nf_scl;  m_sda_f = nf_sda;
  endtask

  // ---------------- observation counters ----------------
  int cyc, n_rise, n_fall, n_start, n_stop, n_tmo, n_busy, n_gap;
  int first_sda0, first_start;
  bit in_xfer = 0;
  bit busy_at_tmo = 1;

  task automatic clear_counts();
    cyc = 0; n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
    n_tmo = 0; n_busy = 0; n_gap = 0; first_sda0 = -1; first_start = -1;
  endtask

  task automatic observe();
    if (bus.scl_rise)  n_rise++;
    if (bus.scl_fall)  n_fall++;
    if (bus.start_det) n_start++;
    if (bus.stop_det)  n_stop++;
    if (bus.bus_busy)  n_busy++;
    if (bus.timeout) begin
      n_tmo++;
      busy_at_tmo = bus.bus_busy;
    end
    if (!bus.sda_f && first_sda0 < 0) first_sda0 = cyc;
    if (bus.start_det && first_start < 0) first_start = cyc;
    if (bus.start_det) in_xfer = 1;
    if (in_xfer && !bus.stop_det && !bus.timeout && !bus.bus_busy) n_gap++;
    if (bus.stop_det || bus.timeout || !rst_n) in_xfer = 0;
  endtask

  // One clk cycle: drive pads, advance model at the edge, compare at negedge.
  task automatic cycle(input bit scl, input bit sda);
    cur_scl = scl; cur_sda = sda;
    bus.scl_in = scl; bus.sda_in = sda;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("scl_f",     int'(bus.scl_f),     int'(m_scl_f));
    check("sda_f",     int'(bus.sda_f),     int'(m_sda_f));
    check("scl_rise",  int'(bus.scl_rise),  int'(m_rise));
    check("scl_fall",  int'(bus.scl_fall),  int'(m_fall));
    check("start_det", int'(bus.start_det), int'(m_start));
    check("stop_det",  int'(bus.stop_det),  int'(m_stop));
    check("bus_busy",  int'(bus.bus_busy),  int'(m_busy));
    check("timeout",   int'(bus.timeout),   int'(m_tmo));
    observe();
  endtask

  // ---------------- bus-level stimulus ----------------
  bit glitch_en = 0;

  task automatic hold(input bit scl, input bit sda, input int n);
    for (int i = 0; i < n; i++) cycle(scl, sda);
  endtask

  task automatic hold_x(input bit scl, input bit sda, input int n);
    int g;
    hold(scl, sda, n);
    if (glitch_en && $urandom_range(0, 3) == 0) begin
      g = $urandom_range(1, FL);
      if ($urandom_range(0, 1) == 1) hold(!scl, sda, g);
      else hold(scl, !sda, g);
      hold(scl, sda, n);
    end
  endtask

  task automatic i2c_start(input int h);
    hold_x(1, 1, h); hold_x(1, 0, h); hold_x(0, 0, h);
  endtask

  task automatic i2c_rstart(input int h);
    hold_x(0, 1, h); hold_x(1, 1, h); hold_x(1, 0, h); hold_x(0, 0, h);
  endtask

  task automatic i2c_bit(input bit b, input int h);
    hold_x(0, b, h); hold_x(1, b, h); hold_x(0, b, h);
  endtask

  task automatic i2c_byte(input logic [7:0] v, input int h);
    for (int i = 7; i >= 0; i--) i2c_bit(v[i], h);
    i2c_bit(1'b0, h);  // ACK clock
  endtask

  task automatic i2c_stop(input int h);
    hold_x(0, 0, h); hold_x(1, 0, h); hold_x(1, 1, h);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int h;
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    model_reset();
    clear_counts();
    @(negedge clk);

    // Reset, then release with an idle bus.
    hold(1, 1, 4);
    rst_n = 1'b1;
    clear_counts();
    hold(1, 1, 8);
    check("idle_busy_cycles", n_busy, 0);
    check("idle_strobes", n_rise + n_fall + n_start + n_stop + n_tmo, 0);

    // SDA low for 2 cycles with SCL high: filtered away.
    clear_counts();
    hold(1, 0, 2);
    hold(1, 1, 10);
    check("short_pulse_sda_f", first_sda0, -1);
    check("short_pulse_start", n_start, 0);

    // Same pulse held 3 cycles: sda_f low at cycle 5, start_det at cycle 6.
    clear_counts();
    hold(1, 0, 3);
    hold(1, 1, 12);
    check("sda_f_latency", first_sda0, 5);
    check("start_latency", first_start, 6);
    check("pulse3_stop", n_stop, 1);

    // Full START, one byte plus ACK, STOP.
    clear_counts();
    i2c_start(FL + 2);
    n_rise = 0;
    i2c_byte(8'hA5, FL + 2);
    check("byte_rises", n_rise, 9);
    i2c_stop(FL + 2);
    hold(1, 1, FL + 6);
    check("xfer_starts", n_start, 1);
    check("xfer_stops", n_stop, 1);
    check("xfer_busy_gap", n_gap, 0);
    check("xfer_end_busy", int'(bus.bus_busy), 0);

    // Repeated START while busy: no drop of bus_busy.
    clear_counts();
    i2c_start(FL + 3);
    i2c_byte(8'h3C, FL + 3);
    i2c_rstart(FL + 3);
    i2c_byte(8'hC3, FL + 3);
    i2c_stop(FL + 3);
    hold(1, 1, FL + 6);
    check("rstart_starts", n_start, 2);
    check("rstart_stops", n_stop, 1);
    check("rstart_busy_gap", n_gap, 0);

    // SCL and SDA changing in the same cycle: edge strobe only.
    clear_counts();
    hold(0, 0, FL + 4);
    hold(1, 1, FL + 6);
    check("simul_falls", n_fall, 1);
    check("simul_rises", n_rise, 1);
    check("simul_start", n_start, 0);
    check("simul_stop", n_stop, 0);

    // SCL stuck low after START.
    clear_counts();
    i2c_start(FL + 2);
    hold(0, 0, 2 * TMO + 50);
`ifdef I2C_BUS_TIMEOUT_EN
    check("tmo_pulses", n_tmo, 1);
    check("tmo_busy_same_cycle", int'(busy_at_tmo), 0);
    check("tmo_busy_after", int'(bus.bus_busy), 0);
`else
    check("tmo_pulses", n_tmo, 0);
    check("tmo_busy_after", int'(bus.bus_busy), 1);
`endif
    i2c_stop(FL + 2);
    hold(1, 1, FL + 6);
    check("tmo_end_busy", int'(bus.bus_busy), 0);

    // Reset asserted mid-transfer drops bus_busy at once; the rest of the
    // transfer is ignored until a new START.
    i2c_start(FL + 2);
    i2c_bit(1'b1, FL + 2);
    check("busy_before_reset", int'(bus.bus_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_busy", int'(bus.bus_busy), 0);
    check("reset_scl_f", int'(bus.scl_f), 1);
    model_reset();
    hold(0, 1, 3);
    rst_n = 1'b1;
    clear_counts();
    i2c_bit(1'b0, FL + 2);
    i2c_bit(1'b1, FL + 2);
    hold(0, 1, FL + 2);
    hold(1, 1, FL + 6);
    check("post_reset_busy", n_busy, 0);
    check("post_reset_start", n_start, 0);

    // Randomized transactions with glitches, checked cycle by cycle.
    glitch_en = 1;
    for (int t = 0; t < 30; t++) begin
      h = $urandom_range(FL + 1, FL + 5);
      i2c_start(h);
      for (int b = 0; b < int'($urandom_range(1, 2)); b++) begin
        if (b > 0 && $urandom_range(0, 2) == 0) i2c_rstart(h);
        i2c_byte(8'($urandom_range(0, 255)), h);
      end
      i2c_stop(h);
      hold_x(1, 1, h + 2);
    end
    glitch_en = 0;
    hold(1, 1, FL + 8);
    check("final_busy", int'(bus.bus_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Front-end stage directly upstream of the I2C slave's protocol state machine. It samples the raw SCL/SDA pad inputs, synchronizes them to `clk`, and removes glitches. It then produces single-cycle SCL edge strobes, START/STOP detect pulses, a bus-busy flag and an optional SCL-stuck-low timeout. The slave consumes these strobes instead of sampling `scl`/`sda` directly.

## Interface
Parameters:
- FILTER_LEN, 3: consecutive `clk` samples a synchronized line must hold a new level before the filtered output follows it; legal range 1..15.
- TIMEOUT_CYCLES, 50000: `clk` cycles of SCL held low while busy before timeout is declared (1 ms at 50 MHz); legal range 2..2^20-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  reset, asynchronous assert, active-low (0 = reset).
- scl_in  input  1  raw SCL pad input, asynchronous to `clk`.
- sda_in  input  1  raw SDA pad input, asynchronous to `clk`.
- scl_f  output  1  filtered SCL level.
- sda_f  output  1  filtered SDA level.
- scl_rise  output  1  one-cycle pulse on a 0→1 transition of `scl_f`.
- scl_fall  output  1  one-cycle pulse on a 1→0 transition of `scl_f`.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- bus_busy  output  1  high from START until STOP or timeout.
- timeout  output  1  one-cycle pulse when SCL is held low beyond TIMEOUT_CYCLES.

## Operation
- Synchronizer: two flops per line, reset to 1 (idle bus).
- Glitch filter, per line: a counter, 4 bits wide, counts while the synchronized value differs from the filtered value. It clears whenever they match. When the count reaches FILTER_LEN-1 while still differing, the filtered value takes the synchronized value and the counter clears. Pulses shorter than FILTER_LEN samples never reach `scl_f`/`sda_f`.
- Edge/condition detection compares the filtered values with their registered previous values (`scl_p`, `sda_p`):
  - scl_rise = !scl_p & scl_f; scl_fall = scl_p & !scl_f.
  - start_det = scl_p & scl_f & sda_p & !sda_f.
  - stop_det = scl_p & scl_f & !sda_p & sda_f.
  - If SCL and SDA change in the same cycle, no START/STOP is reported. The SCL edge strobe is still reported.
- bus_busy: set on start_det (including a repeated START while already busy, where it stays 1). Cleared on stop_det or timeout. If start_det and timeout occur in the same cycle, start_det wins and bus_busy = 1.
- Timeout counter (20 bits): increments while bus_busy & !scl_f, and clears otherwise. On reaching TIMEOUT_CYCLES-1 it pulses timeout, clears bus_busy, and clears itself. It cannot re-fire until a new START occurs.
- Reset mid-transfer: all state returns to reset values immediately. After release, a transfer already in progress is ignored until the next START.

## Timing
- Reset values: scl_f = 1, sda_f = 1, scl_rise = scl_fall = start_det = stop_det = bus_busy = timeout = 0. Counters are 0 and scl_p/sda_p are 1.
- Latency from a pad transition (held stable) to the filtered output is 2 + FILTER_LEN cycles.
- All strobes are registered and asserted in the cycle after the `scl_f`/`sda_f` change, so pad to strobe is 3 + FILTER_LEN cycles.
- All outputs are registered; there are no combinational paths from input to output.
- Strobes are exactly one cycle wide. The consumer must sample every cycle; there is no handshake.
- timeout asserts on the cycle after the TIMEOUT_CYCLES-th consecutive low-SCL busy cycle. bus_busy falls on that same cycle.

## Configuration
- Macro: `I2C_BUS_TIMEOUT_EN`.
- Defined: the timeout counter and timeout logic are built as described.
- Undefined: no counter is synthesized, timeout is tied to 0, and bus_busy clears only on stop_det. TIMEOUT_CYCLES is ignored.

## Structure
- Shared package `i2c_pkg` holds:
  - the default constants for FILTER_LEN and TIMEOUT_CYCLES;
  - the idle-level constant (1'b1);
  - the filter counter width (4).
- Sub-module `i2c_glitch_filter` (synchronizer plus filter for one line, parameterized by FILTER_LEN) is instantiated twice, once for SCL and once for SDA.
- Edge detection, bus_busy and timeout logic stay in the top of this block.

## Test plan
- Reset release with both lines at 1: all outputs hold reset values. A reset asserted while bus_busy = 1 drops it in the same cycle.
- FILTER_LEN = 3, SDA low pulse of 2 cycles while SCL = 1: no change on sda_f and no start_det. The same pulse held 3 cycles gives sda_f = 0 at cycle 5 and start_det at cycle 6.
- Full START, 8 SCL clocks, STOP: exactly 9 scl_rise pulses (8 data clocks plus ACK, issued), 1 start_det and 1 stop_det. bus_busy is high between start_det and stop_det.
- Repeated START while busy: start_det pulses and bus_busy stays 1 with no intermediate drop. SCL and SDA toggled in the same cycle give an edge strobe but no start_det/stop_det.
- `I2C_BUS_TIMEOUT_EN` defined, TIMEOUT_CYCLES = 100, SCL held low after START: timeout pulses once, bus_busy goes to 0 on that cycle, and there is no second pulse.
- Macro undefined, same stimulus: timeout stays 0 and bus_busy stays 1 until STOP.
